mem_burst_ctrl: RTL and testbench

Parametrised byte-serial memory controller between the instruction cache, the load/store buffer (LSB) and the 8-bit RAM port. Fetches are configurable-length line bursts; loads and stores are 1/2/4 bytes with sign/zero extension. Address issue is pipelined against a parametrised RAM read latency. Simultaneous requests are arbitrated round-robin, not fixed priority.

---
 rtl/mem_burst_if.sv | 36 +++
 rtl/mem_burst_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_if.sv
// Bundle of the fetch, load/store and byte-wide RAM signals around mem_burst_ctrl.
// The controller connects through the slave view and the requesters/RAM through the master view.
interface mem_burst_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 4
);
  logic                    if_req;
  logic [ADDR_W-1:0]       if_addr;
  logic                    if_valid;
  logic [8*LINE_BYTES-1:0] if_line;

  logic                    ls_req;
  logic                    ls_wr;
  logic [ADDR_W-1:0]       ls_addr;
  logic [1:0]              ls_size;
  logic                    ls_signed;
  logic [31:0]             ls_wdata;
  logic                    ls_valid;
  logic [31:0]             ls_rdata;

  logic                    ram_en;
  logic                    ram_wr;
  logic [ADDR_W-1:0]       ram_addr;
  logic [7:0]              ram_dout;
  logic [7:0]              ram_din;

  modport slave (
    input  if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size, ls_signed, ls_wdata, ram_din,
    output if_valid, if_line, ls_valid, ls_rdata, ram_en, ram_wr, ram_addr, ram_dout
  );

  modport master (
    output if_req, if_addr, ls_req, ls_wr, ls_addr, ls_size, ls_signed, ls_wdata, ram_din,
    input  if_valid, if_line, ls_valid, ls_rdata, ram_en, ram_wr, ram_addr, ram_dout
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Byte-serial memory controller: round-robin between line fetches and 1/2/4-byte loads/stores,
// issuing one RAM byte per cycle with reads captured RD_LAT cycles after their address.
module mem_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 4,
  parameter int RD_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  mem_burst_if.slave  bus
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int CNT_W  = OFF_W + 1;
  localparam int LINE_W = 8 * LINE_BYTES;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE, GAP} state_t;

  state_t              state;
  state_t              state_next;

  logic                last_grant;
  logic                cur_ls;
  logic [ADDR_W-1:0]   base;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [31:0]         wdata_q;
  logic [CNT_W-1:0]    nbytes;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    cap_cnt;
  logic [RD_LAT-1:0]   lat_pipe;
  logic [LINE_W-1:0]   line_buf;
  logic [LINE_W-1:0]   buf_next;
  logic [LINE_W-1:0]   if_line_q;
  logic [31:0]         ls_rdata_q;
  logic [31:0]         ld_ext;

  logic                grant_if;
  logic                grant_ls;
  logic [CNT_W-1:0]    ls_nbytes;
  logic                reading;
  logic                issuing;
  logic                capture;
  logic                last_cap;

  // last_grant = 1 means the load/store channel won the previous arbitration
  always_comb begin
    grant_ls = bus.ls_req && (!bus.if_req || !last_grant);
    grant_if = bus.if_req && (!bus.ls_req || last_grant);
    case (bus.ls_size)
      2'd0:    ls_nbytes = CNT_W'(1);
      2'd1:    ls_nbytes = CNT_W'(2);
      default: ls_nbytes = CNT_W'(4);
    endcase
  end

  always_comb begin
    reading  = (state == FETCH) || (state == LOAD);
    issuing  = (reading || (state == STORE)) && (issue_cnt < nbytes);
    capture  = reading && lat_pipe[RD_LAT-1];
    last_cap = capture && (cap_cnt == nbytes - CNT_W'(1));
    buf_next = line_buf;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (capture && (cap_cnt == CNT_W'(i))) begin
        buf_next[8*i +: 8] = bus.ram_din;
      end
    end
    case (size_q)
      2'd0:    ld_ext = {{24{signed_q & buf_next[7]}}, buf_next[7:0]};
      2'd1:    ld_ext = {{16{signed_q & buf_next[15]}}, buf_next[15:0]};
      default: ld_ext = buf_next[31:0];
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_next = FETCH;
        end else if (grant_ls) begin
          state_next = bus.ls_wr ? STORE : LOAD;
        end
      end
      FETCH, LOAD: begin
        if (last_cap) begin
          state_next = DONE;
        end
      end
      STORE: begin
        if (issue_cnt == nbytes - CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_next;
    end
  end

  // Request fields are latched only at grant, so requesters may change inputs mid-transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
      cur_ls     <= 1'b0;
      base       <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      nbytes     <= '0;
      issue_cnt  <= '0;
      cap_cnt    <= '0;
      lat_pipe   <= '0;
      line_buf   <= '0;
      if_line_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      if (state == IDLE) begin
        if (grant_if || grant_ls) begin
          last_grant <= grant_ls;
          cur_ls     <= grant_ls;
          base       <= grant_ls ? bus.ls_addr : (bus.if_addr & ~ADDR_W'(LINE_BYTES - 1));
          nbytes     <= grant_ls ? ls_nbytes : CNT_W'(LINE_BYTES);
          size_q     <= bus.ls_size;
          signed_q   <= bus.ls_signed;
          wdata_q    <= bus.ls_wdata;
          issue_cnt  <= '0;
          cap_cnt    <= '0;
          lat_pipe   <= '0;
          line_buf   <= '0;
        end
      end else begin
        if (issuing) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
        lat_pipe[0] <= issuing && reading;
        for (int i = 1; i < RD_LAT; i++) begin
          lat_pipe[i] <= lat_pipe[i-1];
        end
        if (capture) begin
          cap_cnt <= cap_cnt + CNT_W'(1);
        end
        line_buf <= buf_next;
        if (last_cap && !cur_ls) begin
          if_line_q <= buf_next;
        end
        if (last_cap && cur_ls) begin
          ls_rdata_q <= ld_ext;
        end
      end
    end
  end

  assign bus.ram_en   = issuing;
  assign bus.ram_wr   = issuing && (state == STORE);
  assign bus.ram_addr = issuing ? (base + ADDR_W'(issue_cnt)) : '0;
  assign bus.ram_dout = (issuing && (state == STORE)) ? wdata_q[{issue_cnt[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.if_valid = (state == DONE) && !cur_ls;
  assign bus.ls_valid = (state == DONE) && cur_ls;
  assign bus.if_line  = if_line_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Testbench for mem_burst_ctrl: instance A (4-byte lines, 1-cycle RAM) and
// instance B (16-byte lines, 3-cycle RAM), each with its own behavioural RAM.
module tb_mem_burst_ctrl;

  localparam int AW   = 32;
  localparam int LBA  = 4;
  localparam int LATA = 1;
  localparam int LBB  = 16;
  localparam int LATB = 3;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  bit           arb_q[$];

  mem_burst_if #(.ADDR_W(AW), .LINE_BYTES(LBA)) a_if ();
  mem_burst_if #(.ADDR_W(AW), .LINE_BYTES(LBB)) b_if ();

  mem_burst_ctrl #(.ADDR_W(AW), .LINE_BYTES(LBA), .RD_LAT(LATA)) dut_a (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(a_if)
  );

  mem_burst_ctrl #(.ADDR_W(AW), .LINE_BYTES(LBB), .RD_LAT(LATB)) dut_b (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(b_if)
  );

  // RAM A: fixed preload plus a log of written bytes (latest write wins)
  logic [31:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  int          wr_n  = 0;
  logic [7:0]  din_a = 8'h00;

  function automatic logic [7:0] initA(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h104: return 8'h55;
      32'h020: return 8'h80;
      32'h030: return 8'h01;
      32'h031: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rdA(input logic [31:0] a);
    logic [7:0] v;
    v = initA(a);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_n && wr_addr[i] == a) v = wr_data[i];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      if (a_if.ram_en && a_if.ram_wr) begin
        wr_addr[wr_n % 16] <= a_if.ram_addr;
        wr_data[wr_n % 16] <= a_if.ram_dout;
        wr_n               <= wr_n + 1;
      end
      din_a <= (a_if.ram_en && !a_if.ram_wr) ? rdA(a_if.ram_addr) : 8'h00;
    end
  end
  assign a_if.ram_din = din_a;

  // RAM B: read-only pattern memory behind a LATB-deep pipeline
  logic [7:0] pipe_b [LATB];

  function automatic logic [7:0] patB(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      pipe_b[0] <= (b_if.ram_en && !b_if.ram_wr) ? patB(b_if.ram_addr) : 8'h00;
      for (int i = 1; i < LATB; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign b_if.ram_din = pipe_b[LATB-1];

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with A idle; ends at a negedge with A back in IDLE
  task automatic waitDoneA(input bit fetch, input int exp_lat, input bit has_data, input string tag);
    int k;
    bit seen;
    logic [127:0] expd;
    logic [127:0] obs;
    k    = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    a_if.if_addr   = '1;
    a_if.ls_addr   = '1;
    a_if.ls_wdata  = '0;
    a_if.ls_size   = 2'd0;
    a_if.ls_signed = ~a_if.ls_signed;
    while (!seen && k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      seen = fetch ? a_if.if_valid : a_if.ls_valid;
    end
    checkOutput({tag, " latency"}, seen ? k : 999, exp_lat);
    a_if.if_req = 1'b0;
    a_if.ls_req = 1'b0;
    if (has_data) begin
      expd = exp_q.pop_front();
      obs  = fetch ? 128'(a_if.if_line) : 128'(a_if.ls_rdata);
      checkOutput({tag, " data"}, obs, expd);
    end
    @(negedge clk);
    checkOutput({tag, " pulse"}, fetch ? a_if.if_valid : a_if.ls_valid, 0);
    @(negedge clk);
  endtask

  task automatic applyFetchA(input logic [31:0] addr, input logic [31:0] expline, input string tag);
    a_if.if_addr = addr;
    a_if.if_req  = 1'b1;
    exp_q.push_back(128'(expline));
    waitDoneA(1'b1, LBA + LATA, 1'b1, tag);
  endtask

  task automatic applyLoadA(input logic [31:0] addr, input logic [1:0] size, input bit sgn,
                            input logic [31:0] expv, input string tag);
    int nb;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a_if.ls_wr     = 1'b0;
    a_if.ls_addr   = addr;
    a_if.ls_size   = size;
    a_if.ls_signed = sgn;
    a_if.ls_req    = 1'b1;
    exp_q.push_back(128'(expv));
    waitDoneA(1'b0, nb + LATA, 1'b1, tag);
  endtask

  task automatic applyStoreA(input logic [31:0] addr, input logic [31:0] data, input string tag);
    a_if.ls_wr     = 1'b1;
    a_if.ls_addr   = addr;
    a_if.ls_size   = 2'd2;
    a_if.ls_signed = 1'b0;
    a_if.ls_wdata  = data;
    a_if.ls_req    = 1'b1;
    waitDoneA(1'b0, 4, 1'b0, tag);
  endtask

  initial begin
    bit            saw;
    bit            expc;
    int            k;
    logic [127:0]  expline;

    rst = 1'b1;
    rdy = 1'b1;
    a_if.if_req = 0; a_if.if_addr = '0; a_if.ls_req = 0; a_if.ls_wr = 0;
    a_if.ls_addr = '0; a_if.ls_size = '0; a_if.ls_signed = 0; a_if.ls_wdata = '0;
    b_if.if_req = 0; b_if.if_addr = '0; b_if.ls_req = 0; b_if.ls_wr = 0;
    b_if.ls_addr = '0; b_if.ls_size = '0; b_if.ls_signed = 0; b_if.ls_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (a_if.ram_en || b_if.ram_en) saw = 1'b1;
    end
    checkOutput("reset outputs A", {a_if.if_valid, a_if.ls_valid, a_if.ram_en, a_if.ram_wr,
                a_if.ram_addr, a_if.ram_dout, a_if.ls_rdata, a_if.if_line}, '0);
    checkOutput("reset outputs B", {b_if.if_valid, b_if.ls_valid, b_if.ram_en, b_if.ram_wr,
                b_if.ram_addr, b_if.ram_dout, b_if.ls_rdata}, '0);
    checkOutput("reset line B", b_if.if_line, '0);
    checkOutput("idle ram_en", saw, 0);

    applyLoadA(32'h20, 2'd0, 1'b1, 32'hFFFF_FF80, "load byte signed");
    applyLoadA(32'h20, 2'd0, 1'b0, 32'h0000_0080, "load byte unsigned");
    applyLoadA(32'h30, 2'd1, 1'b1, 32'hFFFF_8001, "load half signed");
    applyLoadA(32'h101, 2'd3, 1'b0, 32'h5544_3322, "load misaligned word");
    applyFetchA(32'h102, 32'h4433_2211, "fetch line");
    checkOutput("ls_rdata hold", a_if.ls_rdata, 32'h5544_3322);

    applyStoreA(32'h7FFF_FFFF, 32'hDEAD_BEEF, "store word");
    checkOutput("store bytes", {rdA(32'h8000_0002), rdA(32'h8000_0001),
                rdA(32'h8000_0000), rdA(32'h7FFF_FFFF)}, 32'hDEAD_BEEF);
    applyStoreA(32'hFFFF_FFFE, 32'h0102_0304, "store wrap");
    checkOutput("store wrap bytes", {rdA(32'h0000_0001), rdA(32'h0000_0000),
                rdA(32'hFFFF_FFFF), rdA(32'hFFFF_FFFE)}, 32'h0102_0304);
    applyLoadA(32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0102_0304, "load wrap");
    checkOutput("if_line hold", a_if.if_line, 32'h4433_2211);

    // Both channels held continuously after a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_if.if_addr   = 32'h100;
    a_if.ls_addr   = 32'h20;
    a_if.ls_size   = 2'd0;
    a_if.ls_signed = 1'b0;
    a_if.ls_wr     = 1'b0;
    a_if.if_req    = 1'b1;
    a_if.ls_req    = 1'b1;
    arb_q.push_back(1'b1);
    arb_q.push_back(1'b0);
    arb_q.push_back(1'b1);
    arb_q.push_back(1'b0);
    for (int t = 0; t < 4; t++) begin
      k   = 0;
      saw = 1'b0;
      while (!saw && k < 60) begin
        @(negedge clk);
        k++;
        saw = a_if.if_valid || a_if.ls_valid;
      end
      checkOutput("arb timeout", saw, 1);
      expc = arb_q.pop_front();
      checkOutput("arb order", a_if.ls_valid, expc);
      checkOutput("arb data", expc ? 128'(a_if.ls_rdata) : 128'(a_if.if_line),
                  expc ? 128'h80 : 128'h4433_2211);
      if (t < 3) begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!a_if.ram_en && k < 20);
        checkOutput("arb gap", k, 3);
      end
    end
    a_if.if_req = 1'b0;
    a_if.ls_req = 1'b0;
    repeat (2) @(negedge clk);

    // Long fetch on B with a 5-cycle global stall mid-burst
    b_if.if_addr = 32'h1237;
    b_if.if_req  = 1'b1;
    for (int i = 0; i < LBB; i++) expline[8*i +: 8] = patB(32'h1230 + i);
    exp_q.push_back(expline);
    k   = 0;
    saw = 1'b0;
    @(posedge clk);
    #1 b_if.if_addr = '0;
    while (!saw && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      saw = b_if.if_valid;
      if (k == 6) begin
        checkOutput("B addr before stall", b_if.ram_addr, 32'h1236);
        rdy = 1'b0;
      end
      if (k == 11) begin
        checkOutput("B addr frozen", b_if.ram_addr, 32'h1236);
        rdy = 1'b1;
      end
    end
    checkOutput("B stall latency", saw ? k : 999, LBB + LATB + 5);
    b_if.if_req = 1'b0;
    checkOutput("B line", b_if.if_line, exp_q.pop_front());
    @(negedge clk);
    checkOutput("B pulse", b_if.if_valid, 0);
    @(negedge clk);

    // Reset in the middle of a B burst
    b_if.if_addr = 32'h2000;
    b_if.if_req  = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("B busy before reset", b_if.ram_en, 1);
    rst = 1'b1;
    b_if.if_req = 1'b0;
    @(negedge clk);
    checkOutput("B ram_en after reset", b_if.ram_en, 0);
    checkOutput("B line cleared", b_if.if_line, '0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b_if.if_valid) saw = 1'b1;
    end
    checkOutput("B no valid after abort", saw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
